// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Data-hazard and forwarding controller for the in-order pipeline. A
//   shift-register scoreboard records the destination of every instruction
//   that has left ID (entry 0 = EX, 1 = MM, 2 = WB, ...). Each cycle the ID
//   sources are compared against it to produce stall/bubble requests, a
//   combinational forward select for operands consumed in ID, and a
//   registered forward select for operands consumed in EX.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_src_addr       source addresses, port j at [j*REG_AW +: REG_AW]
//   id_src_used       port j reads a register
//   id_src_early      port j is consumed in ID (branch compare)
//   id_wr_en/addr     destination of the ID instruction
//   id_is_load        ID instruction is a load
//   mem_busy          data memory not ready; freezes the pipeline
//   stall_pc/stall_id hold PC / ID register
//   flush_ex          insert a bubble into EX next cycle
//   fwd_sel_id        per-port select for ID operands (0 = regfile, k = stage k)
//   fwd_sel_ex        per-port select for EX operands, registered
//   perf_stall_cnt    hazard-stall cycle counter (optional)
//   perf_busy_cnt     memory-freeze cycle counter (optional)
//
// Configuration
//   HAZARD_PERF_EN    when defined, builds saturating 32-bit performance
//                     counters; otherwise both counter ports are tied to 0.
module hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC-1:0]        id_src_early,
  input  logic                      id_wr_en,
  input  logic [REG_AW-1:0]         id_wr_addr,
  input  logic                      id_is_load,
  input  logic                      mem_busy,
  output logic                      stall_pc,
  output logic                      stall_id,
  output logic                      flush_ex,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_id,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_ex,
  output logic [31:0]               perf_stall_cnt,
  output logic [31:0]               perf_busy_cnt
);

  logic [FWD_DEPTH-1:0]             ent_wr_q, ent_wr_d;
  logic [FWD_DEPTH-1:0]             ent_ld_q, ent_ld_d;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] ent_addr_q, ent_addr_d;
  logic [NUM_SRC*SEL_W-1:0]         fwd_ex_q, fwd_ex_d;
  logic [NUM_SRC*SEL_W-1:0]         sel_ex_c;
  logic                             hazard;
  logic                             new_wr;

  // ID lookup: youngest matching entry per port decides hazard or select.
  // An EX operand reads stage k+1 one cycle later, so it may use a result
  // produced at the end of stage k; an ID operand must see it already done.
  always_comb begin
    logic found;
    logic mld;
    int   mk;
    int   prod;
    hazard     = 1'b0;
    fwd_sel_id = '0;
    sel_ex_c   = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      found = 1'b0;
      mld   = 1'b0;
      mk    = 0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (id_valid && id_src_used[j] && ent_wr_q[k] &&
            (ent_addr_q[k] == id_src_addr[j*REG_AW +: REG_AW])) begin
          found = 1'b1;
          mld   = ent_ld_q[k];
          mk    = k;
        end
      end
      prod = mld ? LOAD_LAT : 0;
      if (found) begin
        if (id_src_early[j]) begin
          if (mk <= prod) hazard = 1'b1;
          else            fwd_sel_id[j*SEL_W +: SEL_W] = SEL_W'(mk);
        end else begin
          if (mk < prod) hazard = 1'b1;
          else           sel_ex_c[j*SEL_W +: SEL_W] = SEL_W'(mk + 1);
        end
      end
    end
  end

  assign stall_pc = hazard | mem_busy;
  assign stall_id = hazard | mem_busy;
  assign flush_ex = hazard & ~mem_busy;

  // Register 0 is never tracked as a writer.
  assign new_wr = id_valid & ~hazard & id_wr_en & (id_wr_addr != '0);

  always_comb begin
    ent_wr_d   = ent_wr_q;
    ent_ld_d   = ent_ld_q;
    ent_addr_d = ent_addr_q;
    fwd_ex_d   = fwd_ex_q;
    if (!mem_busy) begin
      ent_wr_d = {ent_wr_q[FWD_DEPTH-2:0], new_wr};
      if (id_valid && !hazard) begin
        ent_ld_d   = {ent_ld_q[FWD_DEPTH-2:0], id_is_load};
        ent_addr_d = {ent_addr_q[FWD_DEPTH-2:0], id_wr_addr};
      end else begin
        ent_ld_d   = {ent_ld_q[FWD_DEPTH-2:0], 1'b0};
        ent_addr_d = {ent_addr_q[FWD_DEPTH-2:0], {REG_AW{1'b0}}};
      end
      fwd_ex_d = hazard ? '0 : sel_ex_c;
    end
  end

  // ID -> EX boundary: scoreboard shift and EX forward select.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_wr_q   <= '0;
      ent_ld_q   <= '0;
      ent_addr_q <= '0;
      fwd_ex_q   <= '0;
    end else begin
      ent_wr_q   <= ent_wr_d;
      ent_ld_q   <= ent_ld_d;
      ent_addr_q <= ent_addr_d;
      fwd_ex_q   <= fwd_ex_d;
    end
  end

  assign fwd_sel_ex = fwd_ex_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  assign perf_stall_d = sat_inc(perf_stall_q, hazard & ~mem_busy);
  assign perf_busy_d  = sat_inc(perf_busy_q, mem_busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_busy_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_busy_q  <= perf_busy_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_busy_cnt  = perf_busy_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_busy_cnt  = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard and forwarding controller for the in-order pipeline, generalising the fixed EX/MEM compare logic to an arbitrary number of forwardable stages, source ports and load latency. It keeps a shift-register scoreboard of in-flight destination registers behind ID. Each cycle it produces:
- stall/bubble requests, with a global freeze while data memory is busy;
- a combinational forward select for ID-consumed operands (branch compare);
- a registered forward select for EX operands.

## Interface
- REG_AW, 5, register address width
- NUM_SRC, 2, source operand ports per instruction
- FWD_DEPTH, 3, scoreboard stages behind ID (index 0=EX, 1=MM, 2=WB, ...); must be ≥2
- LOAD_LAT, 1, stage index at whose end load data exists; 1 ≤ LOAD_LAT < FWD_DEPTH
- SEL_W, $clog2(FWD_DEPTH+1), forward select width
- clk  in  1  clock (one clock; all state on rising edge)
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_src_addr  in  NUM_SRC*REG_AW  source register addresses, port j at [j*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  port j actually reads a register
- id_src_early  in  NUM_SRC  port j is consumed in ID (branch compare), not EX
- id_wr_en, id_wr_addr, id_is_load  in  1, REG_AW, 1  destination of the ID instruction
- mem_busy  in  1  data memory not ready; freezes pipeline
- stall_pc, stall_id  out  1  hold PC / ID register
- flush_ex  out  1  insert bubble into EX next cycle
- fwd_sel_id  out  NUM_SRC*SEL_W  combinational; 0=regfile, k=result register of stage k
- fwd_sel_ex  out  NUM_SRC*SEL_W  registered; 0=regfile, k=result register of stage k
- perf_stall_cnt, perf_busy_cnt  out  32 each  performance counters (see Configuration)

## Operation
- Scoreboard entry per stage k: {wr, addr, ld}. wr is forced 0 when the destination addr==0; register 0 never hazards or forwards.
- Produce stage p(entry) = LOAD_LAT if ld, else 0.
- Match(j,k): id_valid & id_src_used[j] & entry[k].wr & entry[k].addr==src[j]. Only the lowest matching k (youngest) is considered per port.
- EX operand (early=0), youngest match k:
  - k < p → hazard.
  - Otherwise the next fwd_sel_ex[j] = k+1.
  - No match → 0.
- ID operand (early=1), youngest match k:
  - k ≤ p → hazard.
  - Otherwise fwd_sel_id[j] = k.
  - No match → 0.
  - fwd_sel_id[j]=0 for non-early ports.
- hazard = OR over ports. stall_pc = stall_id = hazard | mem_busy. flush_ex = hazard & ~mem_busy.
- Advance when ~mem_busy:
  - entry[k+1] ← entry[k];
  - entry[0] ← {id_wr_en & id_wr_addr≠0, id_wr_addr, id_is_load} if id_valid & ~hazard, else all-zero (bubble);
  - fwd_sel_ex ← computed selects, or 0 when hazard.
- When mem_busy: entries and fwd_sel_ex hold; fwd_sel_id still reflects current state.
- The oldest entry (k=FWD_DEPTH-1) is discarded on advance; regfile is assumed written by then.

## Timing
- Reset: all entries zero; fwd_sel_ex=0. Comb outputs then follow: stall_pc=stall_id=mem_busy, flush_ex=0, fwd_sel_id=0.
- Reset mid-stall clears the scoreboard; the next cycle's hazards are recomputed from the empty state.
- Hazard outputs are combinational, valid in the same cycle as ID inputs.
- fwd_sel_ex is 1-cycle latency and aligns with the instruction entering EX.
- Stall counts with default parameters:
  - ALU producer immediately ahead: 0 stalls for EX use, 1 stall for early use.
  - Load immediately ahead: 1 stall for EX use, 2 stalls for early use.
  - Load 2 ahead: 0 stalls for EX use, 1 stall for early use.
- Simultaneous mem_busy and hazard: freeze dominates; no bubble is inserted, and hazard is re-evaluated after mem_busy drops.

## Configuration
- HAZARD_PERF_EN defined:
  - perf_stall_cnt increments on cycles with hazard & ~mem_busy.
  - perf_busy_cnt increments on mem_busy cycles.
  - Both are 32-bit, saturate at 0xFFFF_FFFF and clear on rst.
- Undefined: both ports tied to 0; no counter flops are generated.

## Test plan
- Reset: rst=1 for 2 cycles, then issue addi r1 (wr r1). Expect stall_pc=0, fwd_sel_ex=0, all entries empty.
- ALU→ALU: add r3 then add r4,r3,r5. Expect no stall; second instruction's fwd_sel_ex port0 = 1 in EX.
- Load-use: lw r2 then add r6,r2,r0 (defaults).
  - Expect 1 cycle of stall_pc=stall_id=flush_ex=1.
  - Then fwd_sel_ex port0 = 2.
- Load→branch (early): lw r2 then beq r2,r7.
  - Expect 2 stall cycles.
  - Then fwd_sel_id port0 = 2 with stall=0.
- Register 0 and mem freeze, as two cases:
  - add r0 then use r0 → no stall, sel 0.
  - mem_busy=1 for 3 cycles during a load-use → stall=1, flush_ex=0, entries frozen; on release the 1-cycle load-use stall still occurs.
- Perf (HAZARD_PERF_EN): the above sequence yields perf_stall_cnt=1 and perf_busy_cnt=3.
